// File: rtl/stream_bridge.sv
// stream_bridge: two independent stream FIFOs (address and data) between the
// CONV address generator / data fetch and the compute array.
//   m_addr*/m_data*  : upstream valid/ready streams with first/last sideband
//   s_addr*/s_data*  : downstream valid/ready streams, head-of-FIFO outputs
//   cfg_frames       : data frames per weight-controller event (0 = off)
//   last_for_weight_ctrl : one-cycle pulse after the cfg_frames-th data frame
//   addr_level/data_level : FIFO occupancy, 0..DEPTH
//   proto_err/err_clr     : sticky input framing error and its clear
module stream_bridge #(
    parameter int unsigned AW    = 11,
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FW    = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m_addr,
    input  logic          m_addr_first,
    input  logic          m_addr_last,
    input  logic          m_addr_valid,
    output logic          m_addr_ready,

    output logic [AW-1:0] s_addr,
    output logic          s_addr_first,
    output logic          s_addr_last,
    output logic          s_addr_valid,
    input  logic          s_addr_ready,

    input  logic [DW-1:0] m_data,
    input  logic          m_data_first,
    input  logic          m_data_last,
    input  logic          m_data_valid,
    output logic          m_data_ready,

    output logic [DW-1:0] s_data,
    output logic          s_data_first,
    output logic          s_data_last,
    output logic          s_data_valid,
    input  logic          s_data_ready,

    input  logic [FW-1:0] cfg_frames,
    output logic          last_for_weight_ctrl,
    output logic [LW-1:0] addr_level,
    output logic [LW-1:0] data_level,
    output logic          proto_err,
    input  logic          err_clr
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] payload;
        logic          first;
        logic          last;
    } addr_beat_t;

    typedef struct packed {
        logic [DW-1:0] payload;
        logic          first;
        logic          last;
    } data_beat_t;

    addr_beat_t    addr_mem [DEPTH];
    logic [PW-1:0] addr_wr_ptr;
    logic [PW-1:0] addr_rd_ptr;
    logic          addr_in_frame;
    logic          addr_push_c;
    logic          addr_pop_c;
    logic          addr_err_c;
    addr_beat_t    addr_head_c;

    data_beat_t    data_mem [DEPTH];
    logic [PW-1:0] data_wr_ptr;
    logic [PW-1:0] data_rd_ptr;
    logic          data_in_frame;
    logic          data_push_c;
    logic          data_pop_c;
    logic          data_err_c;
    data_beat_t    data_head_c;

    logic [FW-1:0] frame_cnt;
    logic [FW:0]   frame_next_c;

    // Handshake decode: ready/valid come only from registered level and rst
    assign m_addr_ready = !rst && (addr_level != LW'(DEPTH));
    assign s_addr_valid = (addr_level != '0);
    assign addr_push_c  = m_addr_valid && m_addr_ready;
    assign addr_pop_c   = s_addr_valid && s_addr_ready;

    assign m_data_ready = !rst && (data_level != LW'(DEPTH));
    assign s_data_valid = (data_level != '0);
    assign data_push_c  = m_data_valid && m_data_ready;
    assign data_pop_c   = s_data_valid && s_data_ready;

    // A beat is malformed when first disagrees with being outside a frame
    assign addr_err_c = addr_push_c && (m_addr_first == addr_in_frame);
    assign data_err_c = data_push_c && (m_data_first == data_in_frame);

    // Head entry is blanked while the FIFO is empty
    assign addr_head_c  = s_addr_valid ? addr_mem[addr_rd_ptr] : '0;
    assign s_addr       = addr_head_c.payload;
    assign s_addr_first = addr_head_c.first;
    assign s_addr_last  = addr_head_c.last;

    assign data_head_c  = s_data_valid ? data_mem[data_rd_ptr] : '0;
    assign s_data       = data_head_c.payload;
    assign s_data_first = data_head_c.first;
    assign s_data_last  = data_head_c.last;

    assign frame_next_c = {1'b0, frame_cnt} + (FW+1)'(1);

    // Storage arrays: contents are don't-care until the level covers them
    always_ff @(posedge clk) begin
        if (addr_push_c) begin
            addr_mem[addr_wr_ptr] <= '{payload: m_addr, first: m_addr_first, last: m_addr_last};
        end
        if (data_push_c) begin
            data_mem[data_wr_ptr] <= '{payload: m_data, first: m_data_first, last: m_data_last};
        end
    end

    // Address FIFO pointers, occupancy and framing state
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_wr_ptr   <= '0;
            addr_rd_ptr   <= '0;
            addr_level    <= '0;
            addr_in_frame <= 1'b0;
        end else begin
            if (addr_push_c) begin
                addr_wr_ptr   <= addr_wr_ptr + PW'(1);
                addr_in_frame <= !m_addr_last;
            end
            if (addr_pop_c) begin
                addr_rd_ptr <= addr_rd_ptr + PW'(1);
            end
            addr_level <= addr_level + LW'(addr_push_c) - LW'(addr_pop_c);
        end
    end

    // Data FIFO pointers, occupancy and framing state
    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_ptr   <= '0;
            data_rd_ptr   <= '0;
            data_level    <= '0;
            data_in_frame <= 1'b0;
        end else begin
            if (data_push_c) begin
                data_wr_ptr   <= data_wr_ptr + PW'(1);
                data_in_frame <= !m_data_last;
            end
            if (data_pop_c) begin
                data_rd_ptr <= data_rd_ptr + PW'(1);
            end
            data_level <= data_level + LW'(data_push_c) - LW'(data_pop_c);
        end
    end

    // Sticky framing error; a new error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (addr_err_c || data_err_c) begin
            proto_err <= 1'b1;
        end else if (err_clr) begin
            proto_err <= 1'b0;
        end
    end

    // Output frame counter; >= lets a lowered cfg_frames fire on the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt            <= '0;
            last_for_weight_ctrl <= 1'b0;
        end else begin
            last_for_weight_ctrl <= 1'b0;
            if (data_pop_c && s_data_last) begin
                if (cfg_frames == '0) begin
                    frame_cnt <= '0;
                end else if (frame_next_c >= {1'b0, cfg_frames}) begin
                    frame_cnt            <= '0;
                    last_for_weight_ctrl <= 1'b1;
                end else begin
                    frame_cnt <= frame_next_c[FW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_bridge.sv
// Self-checking bench for stream_bridge: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_stream_bridge;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW    = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic          m_addr_first = 1'b0, m_addr_last = 1'b0, m_addr_valid = 1'b0;
    logic          m_addr_ready;
    logic [AW-1:0] s_addr;
    logic          s_addr_first, s_addr_last, s_addr_valid;
    logic          s_addr_ready = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_data_first = 1'b0, m_data_last = 1'b0, m_data_valid = 1'b0;
    logic          m_data_ready;
    logic [DW-1:0] s_data;
    logic          s_data_first, s_data_last, s_data_valid;
    logic          s_data_ready = 1'b0;
    logic [FW-1:0] cfg_frames = '0;
    logic          last_for_weight_ctrl;
    logic [LW-1:0] addr_level, data_level;
    logic          proto_err;
    logic          err_clr = 1'b0;

    stream_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
        .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
        .s_addr(s_addr), .s_addr_first(s_addr_first), .s_addr_last(s_addr_last),
        .s_addr_valid(s_addr_valid), .s_addr_ready(s_addr_ready),
        .m_data(m_data), .m_data_first(m_data_first), .m_data_last(m_data_last),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .s_data(s_data), .s_data_first(s_data_first), .s_data_last(s_data_last),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .cfg_frames(cfg_frames), .last_for_weight_ctrl(last_for_weight_ctrl),
        .addr_level(addr_level), .data_level(data_level),
        .proto_err(proto_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] p;
        logic        f;
        logic        l;
    } beat_t;

    // Reference model state
    beat_t aq[$];
    beat_t dq[$];
    bit    a_inf, d_inf, exp_err, exp_pulse;
    int    frames_seen;
    int    pulses_seen;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return at posedge+1
    task automatic step();
        beat_t ah, dh;
        bit a_rdy, d_rdy, a_push, a_pop, d_push, d_pop, a_e, d_e;
        @(negedge clk);
        a_rdy = !rst && (aq.size() < DEPTH);
        d_rdy = !rst && (dq.size() < DEPTH);
        ah = (aq.size() != 0) ? aq[0] : '0;
        dh = (dq.size() != 0) ? dq[0] : '0;
        check("addr_level",   64'(addr_level),   64'(aq.size()));
        check("data_level",   64'(data_level),   64'(dq.size()));
        check("m_addr_ready", 64'(m_addr_ready), 64'(a_rdy));
        check("m_data_ready", 64'(m_data_ready), 64'(d_rdy));
        check("s_addr_valid", 64'(s_addr_valid), 64'(aq.size() != 0));
        check("s_data_valid", 64'(s_data_valid), 64'(dq.size() != 0));
        check("s_addr",       64'(s_addr),       64'(ah.p[AW-1:0]));
        check("s_addr_fl",    64'({s_addr_first, s_addr_last}), 64'({ah.f, ah.l}));
        check("s_data",       64'(s_data),       dh.p);
        check("s_data_fl",    64'({s_data_first, s_data_last}), 64'({dh.f, dh.l}));
        check("proto_err",    64'(proto_err),    64'(exp_err));
        check("wc_pulse",     64'(last_for_weight_ctrl), 64'(exp_pulse));
        if (last_for_weight_ctrl) pulses_seen++;
        a_push = m_addr_valid && a_rdy;
        d_push = m_data_valid && d_rdy;
        a_pop  = (aq.size() != 0) && s_addr_ready;
        d_pop  = (dq.size() != 0) && s_data_ready;
        @(posedge clk);
        if (rst) begin
            aq.delete();
            dq.delete();
            a_inf = 0; d_inf = 0; exp_err = 0; exp_pulse = 0; frames_seen = 0;
        end else begin
            exp_pulse = 0;
            if (d_pop && dq[0].l) begin
                if (cfg_frames == 0) begin
                    frames_seen = 0;
                end else begin
                    frames_seen++;
                    if (frames_seen >= int'(cfg_frames)) begin
                        exp_pulse   = 1;
                        frames_seen = 0;
                    end
                end
            end
            a_e = a_push && ((m_addr_first && a_inf) || (!m_addr_first && !a_inf));
            d_e = d_push && ((m_data_first && d_inf) || (!m_data_first && !d_inf));
            if (a_e || d_e) exp_err = 1;
            else if (err_clr) exp_err = 0;
            if (a_push) a_inf = !m_addr_last;
            if (d_push) d_inf = !m_data_last;
            if (a_pop) void'(aq.pop_front());
            if (d_pop) void'(dq.pop_front());
            if (a_push) aq.push_back('{p: 64'(m_addr), f: m_addr_first, l: m_addr_last});
            if (d_push) dq.push_back('{p: m_data, f: m_data_first, l: m_data_last});
        end
        #1;
    endtask

    task automatic drv_addr(input bit v, input bit f, input bit l);
        m_addr_valid = v; m_addr_first = f; m_addr_last = l;
        m_addr = AW'($urandom);
    endtask

    task automatic drv_data(input bit v, input bit f, input bit l, input logic [63:0] p);
        m_data_valid = v; m_data_first = f; m_data_last = l; m_data = p;
    endtask

    initial begin
        a_inf = 0; d_inf = 0; exp_err = 0; exp_pulse = 0; frames_seen = 0; pulses_seen = 0;

        // Reset and fill
        @(posedge clk); #1;
        repeat (3) step();
        rst = 0;
        s_data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drv_data(1, 1, 1, 64'(i));
            step();
        end
        drv_data(0, 0, 0, 0);
        step();
        check("fill_level", 64'(data_level), 64'(DEPTH));

        // Back-to-back streaming after draining
        s_data_ready = 1;
        repeat (5) step();
        for (int i = 0; i < 16; i++) begin
            drv_data(1, 1, 1, 64'(i));
            step();
        end
        drv_data(0, 0, 0, 0);
        repeat (2) step();

        // Full with a simultaneous pop: push refused, taken next cycle
        s_data_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drv_data(1, 1, 1, 64'(32 + i));
            step();
        end
        drv_data(1, 1, 1, 64'(100));
        s_data_ready = 1;
        step();
        s_data_ready = 0;
        step();
        drv_data(0, 0, 0, 0);
        step();
        check("full_pop_level", 64'(data_level), 64'(DEPTH));
        s_data_ready = 1;
        repeat (5) step();

        // Framing errors on the address path
        s_addr_ready = 1;
        drv_addr(1, 1, 0); step();
        drv_addr(1, 1, 0); step();
        drv_addr(1, 0, 1); step();
        drv_addr(0, 0, 0); step();
        check("err_set_restart", 64'(proto_err), 64'(1));
        err_clr = 1; step();
        err_clr = 0; step();
        check("err_cleared", 64'(proto_err), 64'(0));
        drv_addr(1, 0, 0); step();
        drv_addr(1, 0, 1); step();
        drv_addr(0, 0, 0); step();
        check("err_set_outside", 64'(proto_err), 64'(1));

        // Frame events
        cfg_frames = 3;
        pulses_seen = 0;
        for (int i = 0; i < 7; i++) begin
            drv_data(1, 1, 1, {$urandom, $urandom});
            step();
        end
        drv_data(0, 0, 0, 0);
        repeat (3) step();
        check("pulses_cfg3", 64'(pulses_seen), 64'(2));
        cfg_frames = 0;
        pulses_seen = 0;
        for (int i = 0; i < 7; i++) begin
            drv_data(1, 1, 1, {$urandom, $urandom});
            step();
        end
        drv_data(0, 0, 0, 0);
        repeat (3) step();
        check("pulses_cfg0", 64'(pulses_seen), 64'(0));

        // Mid-stream reset with partial count, 2 entries each and an error
        cfg_frames = 3;
        drv_data(1, 1, 1, 64'hA5); step();
        drv_data(0, 0, 0, 0); repeat (2) step();
        s_addr_ready = 0; s_data_ready = 0;
        drv_addr(1, 1, 1); drv_data(1, 1, 1, 64'h11); step();
        drv_addr(1, 0, 1); drv_data(1, 1, 1, 64'h22); step();
        drv_addr(0, 0, 0); drv_data(0, 0, 0, 0); step();
        check("pre_rst_err", 64'(proto_err), 64'(1));
        rst = 1; step();
        rst = 0; step();
        check("post_rst_level", 64'(data_level), 64'(0));
        check("post_rst_err", 64'(proto_err), 64'(0));
        s_data_ready = 1; s_addr_ready = 1;
        pulses_seen = 0;
        for (int i = 0; i < 3; i++) begin
            drv_data(1, 1, 1, 64'(i)); step();
        end
        drv_data(0, 0, 0, 0);
        repeat (3) step();
        check("post_rst_pulse", 64'(pulses_seen), 64'(1));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            err_clr      = ($urandom_range(0, 15) == 0);
            s_addr_ready = ($urandom_range(0, 3) != 0);
            s_data_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) cfg_frames = FW'($urandom_range(0, 4));
            drv_addr($urandom_range(0, 2) != 0, ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 1) == 1);
            drv_data($urandom_range(0, 2) != 0, ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 1) == 1, {$urandom, $urandom});
            step();
        end
        rst = 0;
        drv_addr(0, 0, 0);
        drv_data(0, 0, 0, 0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
